updown_cmd_seq: RTL and testbench

- Command sequencer that drives the load/mode/a inputs of the team's up/down counter (`updown`) and tracks the counter's expected value.
- Takes queued commands over a valid/ready interface, buffers them in a small FIFO, and plays each one out cycle by cycle.
- Runs a reference model of the counter alongside the real one and flags any mismatch against the counter's count output.
- Placed next to `updown` in sequential-circuit test/integration setups.

---
 rtl/updown_cmd_seq_if.sv | 32 +++
 rtl/updown_cmd_seq.sv | 150 +++++++++++++++
 tb/tb_updown_cmd_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/updown_cmd_seq_if.sv
// Command/counter bundle for updown_cmd_seq: command channel in, counter drive out,
// counter count back, plus status. slave = sequencer side, master = driver/bench side.
interface updown_cmd_seq_if #(
    parameter int W    = 4,
    parameter int LENW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_load;
    logic            cmd_mode;
    logic [W-1:0]    cmd_value;
    logic [LENW-1:0] cmd_len;
    logic            load;
    logic            mode;
    logic [W-1:0]    a;
    logic [W-1:0]    count;
    logic            busy;
    logic            cmd_done;
    logic [W-1:0]    exp_count;
    logic            mismatch;
    logic [7:0]      err_cnt;

    modport slave (
        input  cmd_valid, cmd_load, cmd_mode, cmd_value, cmd_len, count,
        output cmd_ready, load, mode, a, busy, cmd_done, exp_count, mismatch, err_cnt
    );

    modport master (
        output cmd_valid, cmd_load, cmd_mode, cmd_value, cmd_len, count,
        input  cmd_ready, load, mode, a, busy, cmd_done, exp_count, mismatch, err_cnt
    );
endinterface

// File: rtl/updown_cmd_seq.sv
// Command sequencer for the updown counter: FIFO of load/run commands, IDLE/LOAD/RUN player,
// shadow counter model. Define UPDOWN_SEQ_CHECK_EN to build the count comparator.
module updown_cmd_seq #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int LENW  = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    updown_cmd_seq_if.slave    sif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    typedef struct packed {
        logic            ld;
        logic            md;
        logic [W-1:0]    val;
        logic [LENW-1:0] len;
    } cmd_t;

    cmd_t            fifo_q [DEPTH];
    logic [AW:0]     wr_q, rd_q;
    logic            full, empty, push, pop;
    cmd_t            head, wr_cmd;

    logic [1:0]      state_q, state_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    a_q, a_d;
    logic            done;
    logic [W-1:0]    exp_q, exp_d;

    // Extra pointer bit tells full from empty when the index bits match.
    assign empty  = (wr_q == rd_q);
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push   = sif.cmd_valid && !full;
    assign pop    = (state_q == S_IDLE) && !empty;
    assign head   = fifo_q[rd_q[AW-1:0]];
    assign wr_cmd = '{ld: sif.cmd_load, md: sif.cmd_mode, val: sif.cmd_value, len: sif.cmd_len};

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_q[AW-1:0]] <= wr_cmd;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        a_d     = a_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head.ld) begin
                        state_d = S_LOAD;
                        a_d     = head.val;
                    end else if (head.len == '0) begin
                        // Zero-length run: retire immediately, mode untouched.
                        done = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        rem_d   = head.len;
                        mode_d  = head.md;
                    end
                end
            end
            S_LOAD: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_RUN: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == LENW'(1)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
        end
    end

    assign sif.load      = (state_q == S_LOAD);
    assign sif.mode      = mode_q;
    assign sif.a         = a_q;
    assign sif.cmd_done  = done;
    assign sif.cmd_ready = !full;
    assign sif.busy      = (state_q != S_IDLE) || !empty;

    // The counter has no enable, so the model steps every cycle.
    assign exp_d = sif.load ? sif.a : (sif.mode ? exp_q - 1'b1 : exp_q + 1'b1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) exp_q <= '0;
        else         exp_q <= exp_d;
    end

    assign sif.exp_count = exp_q;

`ifdef UPDOWN_SEQ_CHECK_EN
    logic       armed_q, mm_q;
    logic [7:0] err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q <= 1'b0;
            mm_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            armed_q <= 1'b1;
            if (armed_q && (sif.count != exp_q)) begin
                mm_q <= 1'b1;
                if (err_q != 8'hFF) err_q <= err_q + 1'b1;
            end
        end
    end

    assign sif.mismatch = mm_q;
    assign sif.err_cnt  = err_q;
`else
    assign sif.mismatch = 1'b0;
    assign sif.err_cnt  = '0;
`endif
endmodule

// File: tb/tb_updown_cmd_seq.sv
// Bench for updown_cmd_seq: behavioural counter plus a slot-schedule reference model
// predicting drive, done, ready, busy and the shadow count cycle by cycle.
module tb_updown_cmd_seq;
    localparam int W = 4, DEPTH = 4, LENW = 8, NC = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    updown_cmd_seq_if #(.W(W), .LENW(LENW)) sif ();
    updown_cmd_seq #(.W(W), .DEPTH(DEPTH), .LENW(LENW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .sif   (sif)
    );

    // Stand-in for the real updown counter, with an override for error injection.
    logic [W-1:0] cnt;
    logic         ovr = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (sif.load) cnt <= sif.a;
        else if (sif.mode) cnt <= cnt - 1'b1;
        else               cnt <= cnt + 1'b1;
    end
    assign sif.count = ovr ? W'(9) : cnt;

    int nvec = 0, nerr = 0;
    int cyc, next_free, occ, err_exp;
    bit m_drv [NC], m_ld [NC], m_md [NC], m_dn [NC];
    logic [W-1:0] m_av [NC];
    int m_pop [NC];
    logic [W-1:0] mval, a_hold;
    bit mode_hold, inj, mm_exp;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NC; i++) begin
            m_drv[i] = 0; m_ld[i] = 0; m_md[i] = 0; m_dn[i] = 0; m_av[i] = '0; m_pop[i] = 0;
        end
        cyc = 0; next_free = 0; occ = 0; mval = '0; a_hold = '0; mode_hold = 0;
    endfunction

    // Each command owns one IDLE fetch slot plus its drive slots; fetch waits for the previous one.
    task automatic check_cycle();
        int c, f, len, acc;
        bit ld_e;
        c = cyc;
        if (c >= NC - 300) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", c, NC - 300);
            $fatal(1);
        end
        if (m_drv[c]) begin
            if (m_ld[c]) a_hold = m_av[c];
            else         mode_hold = m_md[c];
        end
        ld_e = m_drv[c] && m_ld[c];
        chk("load", sif.load, ld_e);
        chk("mode", sif.mode, mode_hold);
        chk("a", sif.a, a_hold);
        chk("cmd_done", sif.cmd_done, m_dn[c]);
        chk("cmd_ready", sif.cmd_ready, occ < DEPTH);
        chk("busy", sif.busy, (occ > 0) || m_drv[c]);
        chk("exp_count", sif.exp_count, mval);
        if (!inj) begin
            chk("mismatch", sif.mismatch, mm_exp);
            chk("err_cnt", sif.err_cnt, err_exp);
        end
        acc = 0;
        if (sif.cmd_valid && occ < DEPTH) begin
            acc = 1;
            f = (c + 1 > next_free) ? c + 1 : next_free;
            len = int'(sif.cmd_len);
            m_pop[f]++;
            if (sif.cmd_load) begin
                m_drv[f+1] = 1; m_ld[f+1] = 1; m_av[f+1] = sif.cmd_value; m_dn[f+1] = 1;
                next_free = f + 2;
            end else if (len == 0) begin
                m_dn[f] = 1;
                next_free = f + 1;
            end else begin
                for (int k = 1; k <= len; k++) begin
                    m_drv[f+k] = 1; m_md[f+k] = sif.cmd_mode;
                end
                m_dn[f+len] = 1;
                next_free = f + len + 1;
            end
        end
        occ = occ + acc - m_pop[c];
        mval = ld_e ? m_av[c] : (mode_hold ? mval - 1'b1 : mval + 1'b1);
    endtask

    task automatic tick();
        #3;
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Entered at posedge+1; leaves the bench at posedge+1 of cycle 1.
    task automatic do_reset();
        sif.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_load", sif.load, 0);
        chk("rst_mode", sif.mode, 0);
        chk("rst_a", sif.a, 0);
        chk("rst_exp_count", sif.exp_count, 0);
        chk("rst_cmd_done", sif.cmd_done, 0);
        chk("rst_cmd_ready", sif.cmd_ready, 1);
        chk("rst_busy", sif.busy, 0);
        chk("rst_mismatch", sif.mismatch, 0);
        chk("rst_err_cnt", sif.err_cnt, 0);
        #2;
        rst_n = 1'b1;
        model_clear();
        mm_exp = 0; err_exp = 0;
        #1;
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input bit ld, input bit md, input int val, input int len);
        bit acc;
        sif.cmd_load  = ld;
        sif.cmd_mode  = md;
        sif.cmd_value = W'(val);
        sif.cmd_len   = LENW'(len);
        sif.cmd_valid = 1'b1;
        acc = 0;
        for (int t = 0; t < 300 && !acc; t++) begin
            acc = (occ < DEPTH);
            tick();
        end
        if (!acc) chk("accept_timeout", 0, 1);
        sif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            if (occ == 0 && next_free <= cyc) ok = 1;
            else tick();
        end
        if (!ok) chk("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        sif.cmd_valid = 1'b0; sif.cmd_load = 1'b0; sif.cmd_mode = 1'b0;
        sif.cmd_value = '0; sif.cmd_len = '0;
        inj = 0; mm_exp = 0; err_exp = 0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        repeat (20) tick();

        // Load 0 then count up 5; wrap down through zero.
        send(1, 0, 0, 0);
        send(0, 0, 0, 5);
        wait_idle();
        send(1, 0, 14, 0);
        send(0, 1, 0, 16);
        wait_idle();

        // Fill the FIFO behind a long run so the fifth push has to wait for a pop.
        send(0, 0, 0, 20);
        send(1, 0, 3, 0);
        send(0, 1, 0, 2);
        send(1, 0, 7, 0);
        send(0, 0, 0, 3);
        send(1, 0, 11, 0);
        wait_idle();

        // Zero-length run, then a reset in the middle of a run.
        send(0, 1, 0, 0);
        wait_idle();
        send(0, 1, 0, 10);
        repeat (3) tick();
        do_reset();
        repeat (5) tick();

        for (int n = 0; n < 60; n++) begin
            send($urandom_range(0, 2) == 0, 1'($urandom), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12)));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();

`ifdef UPDOWN_SEQ_CHECK_EN
        begin
            bit hit;
            hit = 0;
            for (int t = 0; t < 40 && !hit; t++) begin
                if (mval == W'(2)) hit = 1;
                else tick();
            end
            if (!hit) chk("inject_timeout", 0, 1);
            ovr = 1'b1;
            inj = 1;
            repeat (3) tick();
            ovr = 1'b0;
            chk("inj_mismatch", sif.mismatch, 1);
            chk("inj_err_cnt", sif.err_cnt, 3);
            mm_exp = 1; err_exp = 3; inj = 0;
            repeat (6) tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
